// File: rtl/row_to_col.sv
// Row-to-column packer.
// Each accepted row beat carries one fixed-width field per column. Every column
// owns a packer that assembles its fields into MEMORY_WIDTH-bit words, starting
// each value with a length/type header, and a word FIFO that buffers the result.
// An output sequencer then streams whole column values in order: column 0,
// column 1, ... and back to column 0, with output_last on each value's final word.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_HOLD  | just out of reset; input_ready held low for one cycle
// ST_RUN   | normal operation; input_ready follows staging/FIFO space
// sel_q=c  | sequencer presents FIFO c (SEL_c); advances on an accepted last word

// Show-ahead word FIFO: rd_data is the head entry whenever valid is high.
module row_to_col_fifo #(
    parameter int W  = 513,
    parameter int AW = 9
) (
    input  logic         clk,
    input  logic         fifo_rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         valid
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign valid   = (count != '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && valid;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (fifo_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module row_to_col #(
    parameter int MEMORY_WIDTH        = 512,
    parameter int COL_COUNT           = 3,
    parameter int COL_WIDTH           = 64,
    parameter int VALUE_SIZE_BYTES_NO = 2,
    parameter int FIFO_ADDR_BITS      = 9
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [8*VALUE_SIZE_BYTES_NO-1:0]    value_size_data,
    input  logic [COL_COUNT*COL_WIDTH-1:0]      input_data,
    input  logic                                input_valid,
    input  logic                                input_last,
    output logic                                input_ready,
    output logic [MEMORY_WIDTH-1:0]             output_data,
    output logic                                output_valid,
    output logic                                output_last,
    input  logic                                output_ready,
    output logic                                size_error
);
    localparam int LEN_W     = 8 * VALUE_SIZE_BYTES_NO;
    localparam int H         = VALUE_SIZE_BYTES_NO + 6;
    localparam int HDR_BITS  = 8 * H;
    localparam int SLOTS     = MEMORY_WIDTH / COL_WIDTH;
    localparam int HDR_SLOTS = HDR_BITS / COL_WIDTH;
    localparam int PTR_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int SEL_W     = (COL_COUNT > 1) ? $clog2(COL_COUNT) : 1;
    localparam int BPC       = COL_WIDTH / 8;

    typedef enum logic {ST_HOLD, ST_RUN} run_state_t;

    run_state_t            state_q;
    run_state_t            state_d;
    logic [SEL_W-1:0]      sel_q;
    logic [SEL_W-1:0]      sel_d;

    logic                  accept;
    logic                  first_beat;
    logic [LEN_W-1:0]      row_cnt;
    logic [LEN_W-1:0]      size_q;
    logic [LEN_W-1:0]      size_now;
    logic [LEN_W-1:0]      rows_expected;
    logic [LEN_W-1:0]      rows_seen;
    logic [HDR_BITS-1:0]   hdr;

    logic [COL_COUNT-1:0]  stage_ok;
    logic [COL_COUNT-1:0]  fifo_full;
    logic [COL_COUNT-1:0]  fifo_valid;
    logic [COL_COUNT-1:0]  fifo_last;
    logic [COL_COUNT-1:0]  fifo_rd;
    logic [MEMORY_WIDTH-1:0] fifo_data [COL_COUNT];

    // Columns advance in lock step, so one ready covers every packer.
    assign input_ready = (state_q == ST_RUN) && rst && (&stage_ok);
    assign accept      = input_valid && input_ready;

    // Header length is taken live on the first beat and held in the fill word after.
    always_comb begin
        hdr                  = '0;
        hdr[LEN_W-1:0]       = value_size_data + LEN_W'(H);
        hdr[LEN_W +: 8]      = 8'h02;
    end

    assign size_now      = first_beat ? value_size_data : size_q;
    assign rows_expected = size_now / LEN_W'(BPC);
    assign rows_seen     = row_cnt + LEN_W'(1);

    // Row counter and sticky size check; a mismatched last still closes the value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            first_beat <= 1'b1;
            row_cnt    <= '0;
            size_q     <= '0;
            size_error <= 1'b0;
        end else if (accept) begin
            if (first_beat) begin
                size_q <= value_size_data;
            end
            if (input_last) begin
                first_beat <= 1'b1;
                row_cnt    <= '0;
                if (rows_seen != rows_expected) begin
                    size_error <= 1'b1;
                end
            end else begin
                first_beat <= 1'b0;
                row_cnt    <= rows_seen;
            end
        end
    end

    for (genvar c = 0; c < COL_COUNT; c++) begin : g_col
        logic [COL_WIDTH-1:0]    field;
        logic [MEMORY_WIDTH-1:0] fill_q;
        logic [MEMORY_WIDTH-1:0] word;
        logic [PTR_W-1:0]        ptr_q;
        logic                    stg_valid_q;
        logic                    stg_last_q;
        logic [MEMORY_WIDTH-1:0] stg_data_q;
        logic                    wrap;
        logic                    done;
        logic                    drain;
        logic [MEMORY_WIDTH:0]   head;

        assign field = input_data[c*COL_WIDTH +: COL_WIDTH];
        assign wrap  = (ptr_q == PTR_W'(SLOTS - 1));
        assign done  = accept && (wrap || input_last);
        assign drain = stg_valid_q && !fifo_full[c];

        assign stage_ok[c] = !stg_valid_q || drain;

        // Word under construction: fill register plus this beat's field (and header on a first beat).
        always_comb begin
            word = fill_q;
            if (first_beat) begin
                word[HDR_BITS-1:0] = hdr;
            end
            word[ptr_q*COL_WIDTH +: COL_WIDTH] = field;
        end

        // Fill register and slot pointer; after a last the pointer skips the header slots.
        always_ff @(posedge clk) begin
            if (!rst) begin
                fill_q <= '0;
                ptr_q  <= PTR_W'(HDR_SLOTS);
            end else if (accept) begin
                if (done) begin
                    fill_q <= '0;
                    ptr_q  <= input_last ? PTR_W'(HDR_SLOTS) : '0;
                end else begin
                    fill_q <= word;
                    ptr_q  <= ptr_q + PTR_W'(1);
                end
            end
        end

        // Staging register: reloads on completion, empties when the FIFO takes it.
        always_ff @(posedge clk) begin
            if (!rst) begin
                stg_valid_q <= 1'b0;
                stg_last_q  <= 1'b0;
                stg_data_q  <= '0;
            end else if (done) begin
                stg_valid_q <= 1'b1;
                stg_last_q  <= input_last;
                stg_data_q  <= word;
            end else if (drain) begin
                stg_valid_q <= 1'b0;
            end
        end

        assign fifo_rd[c] = output_ready && (sel_q == SEL_W'(c));

        row_to_col_fifo #(
            .W  (MEMORY_WIDTH + 1),
            .AW (FIFO_ADDR_BITS)
        ) u_fifo (
            .clk      (clk),
            .fifo_rst (!rst),
            .wr_en    (drain),
            .wr_data  ({stg_last_q, stg_data_q}),
            .full     (fifo_full[c]),
            .rd_en    (fifo_rd[c]),
            .rd_data  (head),
            .valid    (fifo_valid[c])
        );

        assign fifo_last[c] = head[MEMORY_WIDTH];
        assign fifo_data[c] = head[MEMORY_WIDTH-1:0];
    end

    // Output mux for the selected column; last is qualified by valid.
    always_comb begin
        output_data  = '0;
        output_valid = 1'b0;
        output_last  = 1'b0;
        for (int c = 0; c < COL_COUNT; c++) begin
            if (sel_q == SEL_W'(c)) begin
                output_data  = fifo_data[c];
                output_valid = fifo_valid[c];
                output_last  = fifo_valid[c] && fifo_last[c];
            end
        end
    end

    // Run-phase and sequencer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_HOLD;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state logic: leave hold after one cycle; step columns on each completed value.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_HOLD: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_HOLD;
        endcase
        if (output_valid && output_ready && output_last) begin
            if (sel_q == SEL_W'(COL_COUNT - 1)) begin
                sel_d = '0;
            end else begin
                sel_d = sel_q + SEL_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_row_to_col.sv
// Directed bench for row_to_col at default parameters.
module tb_row_to_col;
    typedef logic [512:0] word_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  value_size_data;
    logic [191:0] input_data;
    logic         input_valid;
    logic         input_last;
    logic         input_ready;
    logic [511:0] output_data;
    logic         output_valid;
    logic         output_last;
    logic         output_ready = 1'b0;
    logic         size_error;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    mode    = 0;
    word_t got_q[$];
    word_t exp_q[$];

    row_to_col dut (
        .clk             (clk),
        .rst             (rst),
        .value_size_data (value_size_data),
        .input_data      (input_data),
        .input_valid     (input_valid),
        .input_last      (input_last),
        .input_ready     (input_ready),
        .output_data     (output_data),
        .output_valid    (output_valid),
        .output_last     (output_last),
        .output_ready    (output_ready),
        .size_error      (size_error)
    );

    always #5 clk = ~clk;

    // Downstream ready pattern: 0 always ready, 1 random with ~30% stall, 2 held off.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       output_ready = 1'b1;
                1:       output_ready = ($urandom_range(0, 99) >= 30);
                default: output_ready = 1'b0;
            endcase
        end
    end

    // Capture every accepted output word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && output_valid && output_ready) begin
                got_q.push_back({output_last, output_data});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input word_t obs, input word_t expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] fld(input int tag, input int c, input int r);
        logic [15:0] t;
        logic [7:0]  cc;
        logic [7:0]  rr;
        t  = tag[15:0];
        cc = c[7:0];
        rr = r[7:0];
        return {32'h0, t, cc, rr};
    endfunction

    // Expected words of one value: header in slot 0, fields from slot 1, zero padding.
    task automatic build_expected(input int nrows, input int size, input int tag);
        word_t w;
        int    p;
        for (int c = 0; c < 3; c++) begin
            w        = '0;
            w[15:0]  = 16'(size + 8);
            w[23:16] = 8'h02;
            p        = 1;
            for (int r = 0; r < nrows; r++) begin
                w[p*64 +: 64] = fld(tag, c, r);
                p++;
                if (p == 8 || r == nrows - 1) begin
                    w[512] = (r == nrows - 1);
                    exp_q.push_back(w);
                    w = '0;
                    p = 0;
                end
            end
        end
    endtask

    task automatic set_beat(input int tag, input int r, input bit last, input int size);
        for (int c = 0; c < 3; c++) begin
            input_data[c*64 +: 64] = fld(tag, c, r);
        end
        input_last      = last;
        value_size_data = 16'(size);
    endtask

    // Present the current beat until accepted or the cycle limit runs out.
    task automatic drive_beat(input int limit, output bit ok);
        ok = 1'b0;
        input_valid = 1'b1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (input_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_value(input int nrows, input int size, input int tag);
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        for (int r = 0; r < nrows; r++) begin
            set_beat(tag, r, (r == nrows - 1), size);
            drive_beat(200, ok);
            if (!ok) all_ok = 1'b0;
        end
        input_valid = 1'b0;
        input_last  = 1'b0;
        check($sformatf("beats_accepted_tag%0d", tag), word_t'(all_ok), word_t'(1));
    endtask

    task automatic wait_words(input int n, input int limit);
        for (int i = 0; i < limit && got_q.size() < n; i++) begin
            @(posedge clk);
        end
        repeat (5) @(posedge clk);
        #1;
        check("word_count", word_t'(got_q.size()), word_t'(n));
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        word_t w;
        bit    ok;
        bit    stalled;
        int    accepted;
        bit    all_ok;

        rst             = 1'b0;
        input_valid     = 1'b0;
        input_last      = 1'b0;
        input_data      = '0;
        value_size_data = '0;
        mode            = 0;

        // Reset values and release timing.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_input_ready", word_t'(input_ready), word_t'(0));
        check("rst_output_valid", word_t'(output_valid), word_t'(0));
        check("rst_output_last", word_t'(output_last), word_t'(0));
        check("rst_size_error", word_t'(size_error), word_t'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("ready_not_yet", word_t'(input_ready), word_t'(0));
        @(negedge clk);
        check("ready_after_release", word_t'(input_ready), word_t'(1));
        @(posedge clk);
        #1;

        // 64-byte value, 8 rows: two words per column.
        build_expected(8, 64, 0);
        send_value(8, 64, 0);
        wait_words(6, 200);
        w = got_q[0];
        check("t1_c0w0_hdr", word_t'(w[63:0]), word_t'(64'h0000_0000_0002_0048));
        check("t1_c0w0_slot2", word_t'(w[191:128]), word_t'(64'h0001));
        check("t1_c0w0_slot7", word_t'(w[511:448]), word_t'(64'h0006));
        check("t1_c0w0_last", word_t'(w[512]), word_t'(0));
        w = got_q[1];
        check("t1_c0w1_slot0", word_t'(w[63:0]), word_t'(64'h0007));
        check("t1_c0w1_upper", word_t'(w[511:64]), word_t'(0));
        check("t1_c0w1_last", word_t'(w[512]), word_t'(1));
        w = got_q[2];
        check("t1_c1w0_slot1", word_t'(w[127:64]), word_t'(64'h0100));
        w = got_q[5];
        check("t1_c2w1_slot0", word_t'(w[63:0]), word_t'(64'h0207));
        compare_all("t1");
        check("t1_size_error", word_t'(size_error), word_t'(0));

        // 56-byte value, 7 rows: exactly one full word per column.
        @(posedge clk);
        #1;
        build_expected(7, 56, 0);
        send_value(7, 56, 0);
        wait_words(3, 200);
        w = got_q[0];
        check("t2_hdr", word_t'(w[63:0]), word_t'(64'h0000_0000_0002_0040));
        check("t2_slot7", word_t'(w[511:448]), word_t'(64'h0006));
        check("t2_last0", word_t'(w[512]), word_t'(1));
        w = got_q[1];
        check("t2_c1_slot1", word_t'(w[127:64]), word_t'(64'h0100));
        w = got_q[2];
        check("t2_last2", word_t'(w[512]), word_t'(1));
        compare_all("t2");

        // Back-to-back values with random downstream stalls.
        mode = 1;
        @(posedge clk);
        #1;
        build_expected(8, 64, 1);
        build_expected(7, 56, 2);
        build_expected(16, 128, 3);
        build_expected(3, 24, 4);
        send_value(8, 64, 1);
        send_value(7, 56, 2);
        send_value(16, 128, 3);
        send_value(3, 24, 4);
        wait_words(21, 2000);
        compare_all("t3");
        mode = 0;
        check("t3_size_error", word_t'(size_error), word_t'(0));

        // Early last: 5 rows against a 64-byte length.
        @(posedge clk);
        #1;
        build_expected(5, 64, 5);
        send_value(5, 64, 5);
        wait_words(3, 200);
        check("t4_size_error", word_t'(size_error), word_t'(1));
        w = got_q[0];
        check("t4_hdr", word_t'(w[63:0]), word_t'(64'h0000_0000_0002_0048));
        check("t4_slot5", word_t'(w[383:320]), word_t'(64'h0005_0004));
        check("t4_pad", word_t'(w[511:384]), word_t'(0));
        check("t4_last", word_t'(w[512]), word_t'(1));
        compare_all("t4");

        // Hold downstream off until FIFO 0 and its staging are full.
        mode = 2;
        @(posedge clk);
        #1;
        accepted = 0;
        stalled  = 1'b0;
        for (int v = 0; v < 600 && !stalled; v++) begin
            for (int r = 0; r < 7 && !stalled; r++) begin
                set_beat(v + 100, r, (r == 6), 56);
                drive_beat(20, ok);
                if (ok) accepted++;
                else    stalled = 1'b1;
            end
        end
        check("full_stalled", word_t'(stalled), word_t'(1));
        check("full_beats", word_t'(accepted), word_t'(3591));
        check("full_ready_low", word_t'(input_ready), word_t'(0));
        check("full_nothing_out", word_t'(got_q.size()), word_t'(0));
        mode = 0;
        all_ok = 1'b1;
        for (int r = 0; r < 7; r++) begin
            set_beat(613, r, (r == 6), 56);
            drive_beat(200, ok);
            if (!ok) all_ok = 1'b0;
        end
        input_valid = 1'b0;
        input_last  = 1'b0;
        check("full_resume", word_t'(all_ok), word_t'(1));
        for (int v = 0; v < 514; v++) begin
            build_expected(7, 56, v + 100);
        end
        wait_words(1542, 5000);
        compare_all("t5");
        check("t5_size_error_sticky", word_t'(size_error), word_t'(1));

        // Reset in the middle of a value, then a clean value.
        @(posedge clk);
        #1;
        for (int r = 0; r < 3; r++) begin
            set_beat(7, r, 1'b0, 64);
            drive_beat(200, ok);
        end
        input_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6_output_valid", word_t'(output_valid), word_t'(0));
        check("t6_size_error", word_t'(size_error), word_t'(0));
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_stale", word_t'(got_q.size()), word_t'(0));
        build_expected(8, 64, 9);
        send_value(8, 64, 9);
        wait_words(6, 200);
        w = got_q[0];
        check("t6_hdr", word_t'(w[63:0]), word_t'(64'h0000_0000_0002_0048));
        check("t6_slot1", word_t'(w[127:64]), word_t'(64'h0009_0000));
        compare_all("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
